// File: rtl/status_monitor_pkg.sv
// status_monitor_pkg: class codes, the class type and a counter sizing helper shared by the
// status_monitor block.
package status_monitor_pkg;

    `include "status_monitor_defs.vh"

    typedef logic [1:0] flag_t;

    // Debounce counter width: clog2(depth), never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/status_monitor_ch.sv
// status_monitor_ch: one status channel. Classifies the raw code, debounces the class and
// keeps a sticky fault latch.
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   status_i   raw status code (SW bits)
//   clear_i    sticky clear, level-sampled
//   flag_o     debounced class (OK/FAULT/WARN)
//   sticky_o   latched fault indicator
//   changed_o  one-cycle pulse when flag_o updates
module status_monitor_ch
    import status_monitor_pkg::*;
#(
    parameter int unsigned SW = 2,
    parameter int unsigned DB = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [SW-1:0] status_i,
    input  logic          clear_i,
    output logic [1:0]    flag_o,
    output logic          sticky_o,
    output logic          changed_o
);

    localparam int unsigned      CntW    = cnt_width(DB);
    localparam logic [CntW-1:0]  CntMax  = CntW'(DB - 1);
    localparam logic [SW-1:0]    AllOnes = '1;

    flag_t           cls;
    flag_t           cand_q, cand_d;
    flag_t           flag_q, flag_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sticky_q, sticky_d;
    logic            changed_q, changed_d;

    // Total classifier: the default arm keeps every code mapped to a class.
    always_comb begin
        cls = FLAG_WARN;
        case (status_i)
            SW'(0), SW'(1): cls = FLAG_OK;
            AllOnes:        cls = FLAG_FAULT;
            default:        cls = FLAG_WARN;
        endcase
    end

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        changed_d = 1'b0;
        sticky_d  = sticky_q;
        if (clear_i) begin
            sticky_d = 1'b0;
        end
        if (cls != cand_q) begin
            // New class restarts the debounce window.
            cand_d = cls;
            cnt_d  = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cand_q != flag_q) begin
            flag_d    = cand_q;
            changed_d = 1'b1;
            // Set beats a simultaneous clear.
            if (cand_q == FLAG_FAULT) begin
                sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand_q    <= FLAG_OK;
            cnt_q     <= '0;
            flag_q    <= FLAG_OK;
            sticky_q  <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
            sticky_q  <= sticky_d;
            changed_q <= changed_d;
        end
    end

    assign flag_o    = flag_q;
    assign sticky_o  = sticky_q;
    assign changed_o = changed_q;

endmodule

// File: rtl/status_monitor_defs.vh
// Shared class codes for status_monitor. This file has no include guard on purpose: it only
// declares localparams and is included inside each scope that needs them (package, bench).
localparam logic [1:0] FLAG_OK    = 2'd0;
localparam logic [1:0] FLAG_FAULT = 2'd1;
localparam logic [1:0] FLAG_WARN  = 2'd2;

// File: rtl/status_monitor.sv
// status_monitor: CH independent debounced status channels with sticky fault latches and a
// shared interrupt.
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   Status   raw codes, channel i at [i*SW +: SW]
//   clear    per-channel sticky clear
//   Flag     debounced classes, channel i at [2*i +: 2]
//   Sticky   latched fault per channel
//   Changed  one-cycle pulse per Flag update
//   Irq      OR of all Sticky bits
module status_monitor #(
    parameter int unsigned CH = 4,
    parameter int unsigned SW = 2,
    parameter int unsigned DB = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*SW-1:0] Status,
    input  logic [CH-1:0]   clear,
    output logic [2*CH-1:0] Flag,
    output logic [CH-1:0]   Sticky,
    output logic [CH-1:0]   Changed,
    output logic            Irq
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        status_monitor_ch #(
            .SW(SW),
            .DB(DB)
        ) u_ch (
            .clk_i    (clk),
            .rst_i    (rst),
            .status_i (Status[i*SW +: SW]),
            .clear_i  (clear[i]),
            .flag_o   (Flag[2*i +: 2]),
            .sticky_o (Sticky[i]),
            .changed_o(Changed[i])
        );
    end

    // Sticky bits are flops, so Irq depends on registers only.
    assign Irq = |Sticky;

endmodule

// File: tb/tb_status_monitor.sv
module tb_status_monitor;

    `include "status_monitor_defs.vh"

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] status;
    logic [3:0] clear;
    logic [7:0] flag;
    logic [3:0] sticky;
    logic [3:0] changed;
    logic       irq;

    logic [3:0] status1;
    logic [0:0] clear1;
    logic [1:0] flag1;
    logic [0:0] sticky1;
    logic [0:0] changed1;
    logic       irq1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    status_monitor #(.CH(4), .SW(2), .DB(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .Status (status),
        .clear  (clear),
        .Flag   (flag),
        .Sticky (sticky),
        .Changed(changed),
        .Irq    (irq)
    );

    status_monitor #(.CH(1), .SW(4), .DB(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .Status (status1),
        .clear  (clear1),
        .Flag   (flag1),
        .Sticky (sticky1),
        .Changed(changed1),
        .Irq    (irq1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [7:0] ef, input logic [3:0] es,
                              input logic [3:0] ec, input logic ei);
        check_eq({tag, ".flag"}, 32'(flag), 32'(ef));
        check_eq({tag, ".sticky"}, 32'(sticky), 32'(es));
        check_eq({tag, ".changed"}, 32'(changed), 32'(ec));
        check_eq({tag, ".irq"}, 32'(irq), 32'(ei));
    endtask

    initial begin
        rst     = 1'b1;
        status  = 8'h00;
        clear   = 4'h0;
        status1 = 4'h0;
        clear1  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_main("reset", 8'h00, 4'h0, 4'h0, 1'b0);
        check_eq("reset.flag1", 32'(flag1), 32'(FLAG_OK));

        // Debounce latency: ch0 0 -> 3, first sampled at e0, Flag loads at e0+3.
        status = 8'h03;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_main("lat_wait", 8'h00, 4'h0, 4'h0, 1'b0);
        end
        tick();
        check_main("lat_load", 8'h01, 4'h1, 4'h1, 1'b1);
        tick();
        check_main("lat_after", 8'h01, 4'h1, 4'h0, 1'b1);

        // Glitch: ch1 WARN for exactly DB samples, then back to OK.
        status = 8'h0B;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_main("glitch_in", 8'h01, 4'h1, 4'h0, 1'b1);
        end
        status = 8'h03;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_main("glitch_out", 8'h01, 4'h1, 4'h0, 1'b1);
        end

        // Default arm: ch2 = 2 classifies WARN, no sticky.
        status = 8'h23;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("warn_wait", 32'(flag), 32'h01);
        end
        tick();
        check_main("warn_load", {FLAG_OK, FLAG_WARN, FLAG_OK, FLAG_FAULT}, 4'h1, 4'h4, 1'b1);
        // ch2 = 1 is OK again.
        status = 8'h13;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("ok_wait", 32'(flag), 32'h21);
        end
        tick();
        check_main("ok_load", 8'h01, 4'h1, 4'h4, 1'b1);

        // ch0 back to OK: sticky must persist.
        status = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        check_main("ch0_ok", 8'h00, 4'h1, 4'h1, 1'b1);
        clear = 4'h1;
        tick();
        clear = 4'h0;
        check_main("clear_ok", 8'h00, 4'h0, 4'h0, 1'b0);

        // Clear coincides with FAULT load: set wins.
        status = 8'h03;
        for (int i = 0; i < 3; i++) tick();
        clear = 4'h1;
        tick();
        check_main("set_wins", 8'h01, 4'h1, 4'h1, 1'b1);
        tick();
        check_main("clear_held", 8'h01, 4'h0, 4'h0, 1'b0);
        clear = 4'h0;

        // Re-latch ch0, then start ch3 and reset mid-debounce.
        status = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        status = 8'h03;
        for (int i = 0; i < 4; i++) tick();
        check_main("prereset", 8'h01, 4'h1, 4'h1, 1'b1);
        status = 8'hC3;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_main("midreset", 8'h00, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_main("post_wait", 8'h00, 4'h0, 4'h0, 1'b0);
        end
        tick();
        check_main("post_load", 8'h41, 4'h9, 4'h9, 1'b1);

        // DB=1, SW=4, CH=1.
        status1 = 4'hF;
        tick();
        check_eq("p_wait", 32'(flag1), 32'(FLAG_OK));
        tick();
        check_eq("p_fault", 32'(flag1), 32'(FLAG_FAULT));
        check_eq("p_changed", 32'(changed1), 32'h1);
        check_eq("p_irq", 32'(irq1), 32'h1);
        status1 = 4'h7;
        tick();
        check_eq("p_hold", 32'(flag1), 32'(FLAG_FAULT));
        tick();
        check_eq("p_warn", 32'(flag1), 32'(FLAG_WARN));
        check_eq("p_sticky", 32'(sticky1), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
